// File: rtl/rec_tq_pkg.sv
// Shared types, saturation limits and the stage-dependent shift lookup
// for the rec_tq transform output stage.
package rec_tq_pkg;

  typedef enum logic [1:0] {
    SZ4  = 2'd0,
    SZ8  = 2'd1,
    SZ16 = 2'd2,
    SZ32 = 2'd3
  } size_e;

  localparam int OUT_MAX = 32767;
  localparam int OUT_MIN = -32768;
  localparam int LANES   = 4;

  // Rounding right-shift for 8-bit video, with L = log2(N) = size + 2:
  // forward pass0 L-1, forward pass1 L+6, inverse pass0 7, inverse pass1 12.
  function automatic logic [3:0] shift_amt(input size_e sz, input logic inv, input logic pass);
    logic [3:0] s;
    if (inv) begin
      s = pass ? 4'd12 : 4'd7;
    end else begin
      s = pass ? (4'd8 + {2'b00, sz}) : (4'd1 + {2'b00, sz});
    end
    return s;
  endfunction

endpackage

// File: rtl/rec_tq_rnd_sat.sv
// One datapath lane: add the rounding offset, arithmetic shift right,
// saturate to the output width. Two register stages, data only.
module rec_tq_rnd_sat
  import rec_tq_pkg::*;
#(
  parameter int IN_W  = 28,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic signed [IN_W-1:0]  data_i,
  input  logic        [3:0]       shift_i,
  output logic signed [OUT_W-1:0] res_o
);

  localparam int SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(OUT_MAX);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(OUT_MIN);

  logic signed [SUM_W-1:0] sum_p1_q;
  logic        [3:0]       shift_p1_q;
  logic signed [OUT_W-1:0] res_p2_q;

  // One extra bit of headroom so the rounding offset can never overflow.
  function automatic logic signed [SUM_W-1:0] round_add(input logic signed [IN_W-1:0] x,
                                                        input logic [3:0] s);
    logic signed [SUM_W-1:0] half;
    logic signed [SUM_W-1:0] xe;
    half = SUM_W'(1) << (s - 4'd1);
    xe   = {x[IN_W-1], x};
    return xe + half;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] c;
    if (v > SAT_HI) begin
      c = SAT_HI;
    end else if (v < SAT_LO) begin
      c = SAT_LO;
    end else begin
      c = v;
    end
    return c[OUT_W-1:0];
  endfunction

  // P1: rounding add; the shift amount travels with the sum
  always_ff @(posedge clk) begin
    sum_p1_q   <= round_add(data_i, shift_i);
    shift_p1_q <= shift_i;
  end

  // P2: arithmetic shift and clamp
  always_ff @(posedge clk) begin
    res_p2_q <= saturate(sum_p1_q >>> shift_p1_q);
  end

  assign res_o = res_p2_q;

endmodule

// File: rtl/rec_tq_round_pack.sv
// rec_tq output stage: rounds/saturates four lanes per beat and packs
// N/4 beats into one transform row for the transpose memory or recon adder.
module rec_tq_round_pack
  import rec_tq_pkg::*;
#(
  parameter int IN_W  = 28,
  parameter int OUT_W = 16,
  parameter int MAX_N = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vld,
  input  logic [1:0]               i_size,
  input  logic                     i_inverse,
  input  logic                     i_pass,
  input  logic                     i_flush,
  input  logic signed [IN_W-1:0]   i_data0,
  input  logic signed [IN_W-1:0]   i_data1,
  input  logic signed [IN_W-1:0]   i_data2,
  input  logic signed [IN_W-1:0]   i_data3,
  output logic                     o_row_vld,
  output logic [MAX_N*OUT_W-1:0]   o_row,
  output logic [1:0]               o_row_size,
  output logic                     o_busy
);

  localparam int ROW_W = MAX_N * OUT_W;
  localparam int CNT_W = $clog2(MAX_N / LANES);

  logic [CNT_W-1:0] cnt_q, cnt_d, last_idx;
  size_e            sz_q, sz_eff, size_p1_q, size_p2_q;
  logic             inv_q, pass_q, inv_eff, pass_eff;
  logic [3:0]       shift_eff;
  logic             accept, last_eff, emit;
  logic             vld_p1_q, vld_p2_q, last_p1_q, last_p2_q;
  logic [CNT_W-1:0] beat_p1_q, beat_p2_q;
  logic [ROW_W-1:0] buf_q, row_d;

  logic signed [IN_W-1:0]  lane_in  [LANES];
  logic signed [OUT_W-1:0] lane_res [LANES];

  assign lane_in[0] = i_data0;
  assign lane_in[1] = i_data1;
  assign lane_in[2] = i_data2;
  assign lane_in[3] = i_data3;

  // Row settings come from the inputs on the first beat, from the latch after
  always_comb begin
    sz_eff   = size_e'(i_size);
    inv_eff  = i_inverse;
    pass_eff = i_pass;
    if (cnt_q != '0) begin
      sz_eff   = sz_q;
      inv_eff  = inv_q;
      pass_eff = pass_q;
    end
    case (sz_eff)
      SZ4:     last_idx = CNT_W'(0);
      SZ8:     last_idx = CNT_W'(1);
      SZ16:    last_idx = CNT_W'(3);
      default: last_idx = CNT_W'(7);
    endcase
    last_eff  = (cnt_q == last_idx);
    shift_eff = shift_amt(sz_eff, inv_eff, pass_eff);
    accept    = i_vld & ~i_flush;
    cnt_d     = cnt_q;
    if (i_flush) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = last_eff ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Beat counter, row-setting latch and the control side of P1/P2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      sz_q      <= SZ4;
      inv_q     <= 1'b0;
      pass_q    <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      beat_p1_q <= '0;
      beat_p2_q <= '0;
      last_p1_q <= 1'b0;
      last_p2_q <= 1'b0;
      size_p1_q <= SZ4;
      size_p2_q <= SZ4;
    end else begin
      cnt_q <= cnt_d;
      if (accept && cnt_q == '0) begin
        sz_q   <= sz_eff;
        inv_q  <= inv_eff;
        pass_q <= pass_eff;
      end
      vld_p1_q <= accept;
      if (accept) begin
        beat_p1_q <= cnt_q;
        last_p1_q <= last_eff;
        size_p1_q <= sz_eff;
      end
      vld_p2_q  <= vld_p1_q & ~i_flush;
      beat_p2_q <= beat_p1_q;
      last_p2_q <= last_p1_q;
      size_p2_q <= size_p1_q;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rec_tq_rnd_sat #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_rnd_sat (
      .clk     (clk),
      .data_i  (lane_in[g]),
      .shift_i (shift_eff),
      .res_o   (lane_res[g])
    );
  end

  // Merge the P2 beat into the row; beat 0 starts from a clean row
  always_comb begin
    row_d = (beat_p2_q == '0) ? '0 : buf_q;
    for (int j = 0; j < LANES; j++) begin
      row_d[(int'(beat_p2_q) * LANES + j) * OUT_W +: OUT_W] = lane_res[j];
    end
  end

  // A flush in the same cycle kills a beat sitting in P2, including a row's last one
  assign emit = vld_p2_q & last_p2_q & ~i_flush;

  // Row assembly buffer (data only)
  always_ff @(posedge clk) begin
    if (vld_p2_q && !i_flush) begin
      buf_q <= row_d;
    end
  end

  // Completed-row output register, held until the next row completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_row_vld  <= 1'b0;
      o_row      <= '0;
      o_row_size <= 2'd0;
    end else begin
      o_row_vld <= emit;
      if (emit) begin
        o_row      <= row_d;
        o_row_size <= size_p2_q;
      end
    end
  end

  assign o_busy = (cnt_q != '0) | vld_p1_q | vld_p2_q;

endmodule
